// File: rtl/watch_pkg.sv
// watch_pkg
// Shared constants and helpers for the watch time-keeping counters.
//   BCD_W, BCD_MAX      : digit width and largest legal BCD digit
//   HOURS_PER_DAY/HALF_DAY : hour-stage constants for the 12h/24h display
//   to_bcd2             : binary 0..99 -> {tens, units} BCD pair
package watch_pkg;

  localparam int              BCD_W         = 4;
  localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
  localparam int              HOURS_PER_DAY = 24;
  localparam int              HALF_DAY      = 12;

  function automatic logic [2*BCD_W-1:0] to_bcd2(input logic [6:0] bin);
    logic [2*BCD_W-1:0] r;
    r[2*BCD_W-1:BCD_W] = 4'(bin / 7'd10);
    r[BCD_W-1:0]       = 4'(bin % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One BCD digit register with load, +1 and -1 and a fixed wrap limit.
//   clk_i, rst_i     : clock, async active-high reset (digit <= RST_VAL)
//   load_i, ld_val_i : load a value (highest priority)
//   inc_i, dec_i     : step up / down; inc at LIMIT -> 0, dec at 0 -> LIMIT
//   digit_q_o        : registered digit
//   digit_d_o        : next-state digit (lets the parent register derived outputs)
//   wrap_o           : this cycle's step wraps the digit
module bcd_digit
  import watch_pkg::*;
#(
  parameter logic [BCD_W-1:0] LIMIT   = BCD_MAX,
  parameter logic [BCD_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] ld_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] digit_q_o,
  output logic [BCD_W-1:0] digit_d_o,
  output logic             wrap_o
);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    wrap_o  = 1'b0;
    if (load_i) begin
      digit_d = ld_val_i;
    end else if (inc_i) begin
      if (digit_q >= LIMIT) begin
        digit_d = '0;
        wrap_o  = 1'b1;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else if (dec_i) begin
      if (digit_q == '0) begin
        digit_d = LIMIT;
        wrap_o  = 1'b1;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) digit_q <= RST_VAL;
    else       digit_q <= digit_d;
  end

  assign digit_q_o = digit_q;
  assign digit_d_o = digit_d;

endmodule

// File: rtl/count_mod_bcd.sv
// count_mod_bcd
// Two-digit BCD modulo counter for one watch stage (seconds, minutes, hours).
//   clk_i, rst_i          : clock, async active-high reset (count <= IVAL)
//   en_i                  : count tick, produces carry_o on wrap
//   inc_i, dec_i          : manual set +1 / -1, wrap silently
//   load_i, ld_tens_i, ld_units_i : BCD load, rejected loads pulse err_o
//   mode12_i              : 12h display (hour stage only)
//   tens_o, units_o, pm_o : registered display digits and PM flag
//   carry_o, err_o        : registered one-cycle pulses
module count_mod_bcd
  import watch_pkg::*;
#(
  parameter int MODULUS   = 24,
  parameter int IVAL      = 0,
  parameter int HOUR_MODE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] ld_tens_i,
  input  logic [BCD_W-1:0] ld_units_i,
  input  logic             mode12_i,
  output logic [BCD_W-1:0] units_o,
  output logic [BCD_W-1:0] tens_o,
  output logic             pm_o,
  output logic             carry_o,
  output logic             err_o
);

  localparam logic [2*BCD_W-1:0] TOP_BCD  = to_bcd2(7'(MODULUS - 1));
  localparam logic [2*BCD_W-1:0] IVAL_BCD = to_bcd2(7'(IVAL));
  localparam logic [7:0]         MOD_W    = 8'(MODULUS);
  localparam bit                 HM12     = (HOUR_MODE != 0) && (MODULUS == HOURS_PER_DAY);

  logic [BCD_W-1:0] tens_q, units_q, tens_d, units_d;
  logic             manual, step_up, step_dn, tick;
  logic             at_top, at_zero, load_ok;
  logic [7:0]       ld_bin;
  logic             dig_load;
  logic [BCD_W-1:0] dig_ld_t, dig_ld_u;
  logic             u_inc, u_dec, u_wrap, t_inc, t_dec;
  logic             t_wrap_unused;

  logic [6:0]       cnt_d;
  logic [BCD_W-1:0] disp_t_d, disp_u_d, disp_t_q, disp_u_q;
  logic             pm_d, pm_q, carry_d, carry_q, err_d, err_q;

  // Strobe arbitration: load beats manual set beats tick; inc and dec together cancel.
  assign manual  = inc_i ^ dec_i;
  assign step_up = !load_i && ((manual && inc_i) || (!manual && en_i));
  assign step_dn = !load_i && manual && dec_i;
  assign tick    = !load_i && !manual && en_i;

  assign at_top  = (tens_q == TOP_BCD[7:4]) && (units_q == TOP_BCD[3:0]);
  assign at_zero = (tens_q == '0) && (units_q == '0);

  assign ld_bin  = 8'(ld_tens_i) * 8'd10 + 8'(ld_units_i);
  assign load_ok = (ld_tens_i <= BCD_MAX) && (ld_units_i <= BCD_MAX) && (ld_bin < MOD_W);

  // Modulus wrap in either direction is done as a parallel load of both digits,
  // so the tens digit never has to wrap by itself.
  assign dig_load = (load_i && load_ok) || (step_up && at_top) || (step_dn && at_zero);
  assign dig_ld_t = load_i ? ld_tens_i  : (step_up ? '0 : TOP_BCD[7:4]);
  assign dig_ld_u = load_i ? ld_units_i : (step_up ? '0 : TOP_BCD[3:0]);

  assign u_inc = step_up && !dig_load;
  assign u_dec = step_dn && !dig_load;
  assign t_inc = u_inc && u_wrap;
  assign t_dec = u_dec && u_wrap;

  bcd_digit #(.LIMIT(BCD_MAX), .RST_VAL(IVAL_BCD[3:0])) u_units (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (dig_load),
    .ld_val_i  (dig_ld_u),
    .inc_i     (u_inc),
    .dec_i     (u_dec),
    .digit_q_o (units_q),
    .digit_d_o (units_d),
    .wrap_o    (u_wrap)
  );

  bcd_digit #(.LIMIT(TOP_BCD[7:4]), .RST_VAL(IVAL_BCD[7:4])) u_tens (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (dig_load),
    .ld_val_i  (dig_ld_t),
    .inc_i     (t_inc),
    .dec_i     (t_dec),
    .digit_q_o (tens_q),
    .digit_d_o (tens_d),
    .wrap_o    (t_wrap_unused)
  );

  // Display is registered from the next count, so mode12_i changes show one cycle later.
  assign cnt_d = 7'(tens_d) * 7'd10 + 7'(units_d);

  always_comb begin
    disp_t_d = tens_d;
    disp_u_d = units_d;
    pm_d     = 1'b0;
    if (HM12 && mode12_i) begin
      pm_d = (cnt_d >= 7'(HALF_DAY));
      if (cnt_d == '0) begin
        disp_t_d = 4'd1;
        disp_u_d = 4'd2;
      end else if (cnt_d > 7'(HALF_DAY)) begin
        {disp_t_d, disp_u_d} = to_bcd2(cnt_d - 7'(HALF_DAY));
      end
    end
  end

  assign carry_d = tick && at_top;
  assign err_d   = load_i && !load_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      disp_t_q <= IVAL_BCD[7:4];
      disp_u_q <= IVAL_BCD[3:0];
      pm_q     <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      disp_t_q <= disp_t_d;
      disp_u_q <= disp_u_d;
      pm_q     <= pm_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign tens_o  = disp_t_q;
  assign units_o = disp_u_q;
  assign pm_o    = pm_q;
  assign carry_o = carry_q;
  assign err_o   = err_q;

endmodule
